// File: rtl/obi_mem_arbiter.sv
// Round-robin OBI arbiter sharing one memory bus among NUM_MASTERS nodes, with an in-order
// ID FIFO for response routing. Define STRELA_ARB_ERR_EN to enable the sticky stray-rvalid flag.

package obi_mem_arbiter_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_mem_arbiter
    import obi_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_i,
    input  obi_req_t  masters_req_i  [NUM_MASTERS],
    output obi_resp_t masters_resp_o [NUM_MASTERS],
    output obi_req_t  slave_req_o,
    input  obi_resp_t slave_resp_i,
    output logic      busy_o,
    output logic      err_o
);

    localparam int unsigned IdW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [IdW:0]    NumM   = (IdW + 1)'(NUM_MASTERS);
    localparam logic [IdW-1:0]  LastId = IdW'(NUM_MASTERS - 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    logic [IdW-1:0]  rr_q, rr_d;
    logic [IdW-1:0]  winner;
    logic [IdW:0]    scan;
    logic            any_req;
    logic            active;
    logic            trans;
    logic            pop;
    logic [IdW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] cnt_q;
    logic [IdW-1:0]  head;

    // Scan from the far end downwards so the closest requester to rr_q wins last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        scan    = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            scan = {1'b0, rr_q} + (IdW + 1)'(k);
            if (scan >= NumM) begin
                scan = scan - NumM;
            end
            if (masters_req_i[scan[IdW-1:0]].req) begin
                winner  = scan[IdW-1:0];
                any_req = 1'b1;
            end
        end
    end

    assign active = rst_ni & ~clr_i;
    assign head   = fifo_q[rd_q];

    always_comb begin
        slave_req_o = '0;
        if (active && any_req && (cnt_q < MaxCnt)) begin
            slave_req_o     = masters_req_i[winner];
            slave_req_o.req = 1'b1;
        end
    end

    assign trans = slave_req_o.req & slave_resp_i.gnt;
    assign pop   = active & slave_resp_i.rvalid & (cnt_q != '0);

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            masters_resp_o[i].gnt    = trans && (winner == IdW'(i));
            masters_resp_o[i].rvalid = pop && (head == IdW'(i));
            masters_resp_o[i].rdata  = slave_resp_i.rdata;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (trans) begin
            rr_d = (winner == LastId) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            rr_q <= rr_d;
            if (trans) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (trans && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!trans && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage only; validity is tracked by the pointers and count above.
    always_ff @(posedge clk_i) begin
        if (trans) begin
            fifo_q[wr_q] <= winner;
        end
    end

    assign busy_o = (cnt_q != '0);

`ifdef STRELA_ARB_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clr_i) begin
            err_q <= 1'b0;
        end else if (slave_resp_i.rvalid && (cnt_q == '0)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
